// File: rtl/assert_mon_pkg.sv
// Shared types and default sizing for the assertion monitor.
// Used by assert_monitor (optional feature macro: ASSERT_MON_TIMESTAMP_EN).
package assert_mon_pkg;

    localparam int unsigned CNT_W_DEF  = 8;
    localparam int unsigned TS_W_DEF   = 16;
    localparam int unsigned SETTLE_DEF = 2;

    // Saturation value of the default-width violation counter
    localparam logic [CNT_W_DEF-1:0] CNT_SAT_DEF = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_FAILED = 2'd3
    } mon_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear; either saturates at all-ones or wraps.
module sat_counter #(
    parameter int unsigned W   = 8,
    parameter bit          SAT = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !(SAT && (count == MAX))) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/assert_monitor.sv
// Turns the 1-bit property signal into sticky/pulsed status, a violation count
// and a first-failure timestamp. Macro ASSERT_MON_TIMESTAMP_EN enables the stamp.
module assert_monitor
    import assert_mon_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned TS_W   = TS_W_DEF,
    parameter int unsigned SETTLE = SETTLE_DEF
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic             I,
    input  logic             valid,
    input  logic             arm,
    input  logic             clear,
    output logic             fail,
    output logic             fail_pulse,
    output logic [CNT_W-1:0] viol_count,
    output logic [TS_W-1:0]  first_ts,
    output logic [1:0]       state
);

    localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

    mon_state_e        state_q;
    mon_state_e        state_d;
    logic [SET_W-1:0]  settle_q;
    logic [SET_W-1:0]  settle_d;
    logic              fail_d;
    logic              pulse_d;
    logic [TS_W-1:0]   ts_d;
    logic [TS_W-1:0]   ts_cap;
    logic              viol;

    // A violation only counts while checking; clear discards it
    assign viol = valid && !I && !clear
                  && ((state_q == ST_CHECK) || (state_q == ST_FAILED));

`ifdef ASSERT_MON_TIMESTAMP_EN
    sat_counter #(
        .W   (TS_W),
        .SAT (1'b0)
    ) u_stamp (
        .clk   (CLK),
        .rst_n (ASYNCRESETN),
        .inc   (1'b1),
        .clr   (1'b0),
        .count (ts_cap)
    );
`else
    assign ts_cap = '0;
`endif

    sat_counter #(
        .W   (CNT_W),
        .SAT (1'b1)
    ) u_viol_cnt (
        .clk   (CLK),
        .rst_n (ASYNCRESETN),
        .inc   (viol),
        .clr   (clear),
        .count (viol_count)
    );

    // Next-state and next-output logic; priority is clear > violation > arm
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        fail_d   = fail;
        pulse_d  = 1'b0;
        ts_d     = first_ts;

        if (clear) begin
            state_d  = ST_IDLE;
            settle_d = '0;
            fail_d   = 1'b0;
            ts_d     = '0;
        end else begin
            if (viol) begin
                fail_d  = 1'b1;
                pulse_d = 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        if (SETTLE == 0) begin
                            state_d = ST_CHECK;
                        end else begin
                            state_d  = ST_SETTLE;
                            settle_d = SET_W'(SETTLE);
                        end
                    end
                end
                ST_SETTLE: begin
                    if (!arm) begin
                        state_d = ST_IDLE;
                    end else if (settle_q == SET_W'(1)) begin
                        state_d = ST_CHECK;
                    end else begin
                        settle_d = settle_q - SET_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (viol) begin
                        state_d = ST_FAILED;
                        ts_d    = ts_cap;
                    end else if (!arm) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FAILED: begin
                    state_d = ST_FAILED;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q    <= ST_IDLE;
            settle_q   <= '0;
            fail       <= 1'b0;
            fail_pulse <= 1'b0;
            first_ts   <= '0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            fail       <= fail_d;
            fail_pulse <= pulse_d;
            first_ts   <= ts_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_assert_monitor.sv
// Self-checking bench for assert_monitor: directed table, hand sequences and
// randomized traffic against a cycle-level behavioural model.
module tb_assert_monitor;

    localparam int unsigned SETTLE = 2;

    logic        CLK = 1'b0;
    logic        ASYNCRESETN = 1'b0;
    logic        I = 1'b1;
    logic        valid = 1'b0;
    logic        arm = 1'b0;
    logic        clear = 1'b0;

    logic        fail;
    logic        fail_pulse;
    logic [7:0]  viol_count;
    logic [15:0] first_ts;
    logic [1:0]  state;

    logic        fail3;
    logic        fail_pulse3;
    logic [2:0]  viol_count3;
    logic [15:0] first_ts3;
    logic [1:0]  state3;

    int errors = 0;
    int checks = 0;

    // Behavioural model: consecutive armed edges decide IDLE/SETTLE/CHECK
    int m_run;
    bit m_failed;
    bit m_pulse;
    int m_cnt;
    int m_cnt3;
    int m_fts;
    int m_stamp;

    typedef struct {
        logic a;
        logic v;
        logic i;
        logic c;
        int   ef;
        int   ep;
        int   ec;
        int   es;
        int   ets;
    } vec_t;

    vec_t tbl[18];

    assert_monitor #(.CNT_W(8), .TS_W(16), .SETTLE(SETTLE)) dut (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .I           (I),
        .valid       (valid),
        .arm         (arm),
        .clear       (clear),
        .fail        (fail),
        .fail_pulse  (fail_pulse),
        .viol_count  (viol_count),
        .first_ts    (first_ts),
        .state       (state)
    );

    assert_monitor #(.CNT_W(3), .TS_W(16), .SETTLE(SETTLE)) dut3 (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .I           (I),
        .valid       (valid),
        .arm         (arm),
        .clear       (clear),
        .fail        (fail3),
        .fail_pulse  (fail_pulse3),
        .viol_count  (viol_count3),
        .first_ts    (first_ts3),
        .state       (state3)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_ts(input int ts);
`ifdef ASSERT_MON_TIMESTAMP_EN
        return ts;
`else
        return 0 * ts;
`endif
    endfunction

    task automatic model_reset();
        m_run    = 0;
        m_failed = 1'b0;
        m_pulse  = 1'b0;
        m_cnt    = 0;
        m_cnt3   = 0;
        m_fts    = 0;
        m_stamp  = 0;
    endtask

    task automatic model_edge();
        bit checking;
        bit v;
        checking = m_failed || (m_run > int'(SETTLE));
        v = !clear && checking && valid && !I;
        if (clear) begin
            m_run    = 0;
            m_failed = 1'b0;
            m_pulse  = 1'b0;
            m_cnt    = 0;
            m_cnt3   = 0;
            m_fts    = 0;
        end else begin
            m_pulse = v;
            if (v) begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt3 < 7) m_cnt3++;
                if (!m_failed) m_fts = m_stamp;
                m_failed = 1'b1;
            end else if (!m_failed) begin
                m_run = arm ? ((m_run > int'(SETTLE)) ? m_run : m_run + 1) : 0;
            end
        end
        m_stamp = (m_stamp + 1) % 65536;
    endtask

    function automatic int model_state();
        if (m_failed) return 3;
        if (m_run == 0) return 0;
        if (m_run <= int'(SETTLE)) return 1;
        return 2;
    endfunction

    task automatic check_model();
        chk("model_fail", 32'(fail), 32'(m_failed));
        chk("model_pulse", 32'(fail_pulse), 32'(m_pulse));
        chk("model_count", 32'(viol_count), 32'(m_cnt));
        chk("model_count3", 32'(viol_count3), 32'(m_cnt3));
        chk("model_first_ts", 32'(first_ts), 32'(exp_ts(m_fts)));
        chk("model_state", 32'(state), 32'(model_state()));
    endtask

    task automatic step(input logic a, input logic v, input logic i, input logic c);
        arm   = a;
        valid = v;
        I     = i;
        clear = c;
        @(posedge CLK);
        model_edge();
        #1;
        check_model();
    endtask

    initial begin
        // a v i c : fail pulse count state ts
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1, 0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1, 0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 2, 0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 1, 3, 3};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1, 0, 1, 3, 3};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1, 3, 3};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 0};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1, 0};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1, 0};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 0, 2, 0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1, 0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1, 0};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 2, 0};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 2, 0};
        tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 1, 3, 17};

        // Reset state while reset is held
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_fail", 32'(fail), 32'd0);
        chk("reset_pulse", 32'(fail_pulse), 32'd0);
        chk("reset_count", 32'(viol_count), 32'd0);
        chk("reset_first_ts", 32'(first_ts), 32'd0);
        chk("reset_state", 32'(state), 32'd0);
        ASYNCRESETN = 1'b1;

        // Directed table: settle window, sticky fail, clear priority, arm drop, valid gating
        for (int k = 0; k < 18; k++) begin
            step(tbl[k].a, tbl[k].v, tbl[k].i, tbl[k].c);
            chk($sformatf("tbl%0d_fail", k), 32'(fail), 32'(tbl[k].ef));
            chk($sformatf("tbl%0d_pulse", k), 32'(fail_pulse), 32'(tbl[k].ep));
            chk($sformatf("tbl%0d_count", k), 32'(viol_count), 32'(tbl[k].ec));
            chk($sformatf("tbl%0d_state", k), 32'(state), 32'(tbl[k].es));
            chk($sformatf("tbl%0d_first_ts", k), 32'(first_ts), 32'(exp_ts(tbl[k].ets)));
        end

        // Async reset while FAILED, with no clock edge in between
        #2;
        arm = 1'b0; valid = 1'b0; I = 1'b1; clear = 1'b0;
        ASYNCRESETN = 1'b0;
        #1;
        chk("async_fail", 32'(fail), 32'd0);
        chk("async_pulse", 32'(fail_pulse), 32'd0);
        chk("async_count", 32'(viol_count), 32'd0);
        chk("async_count3", 32'(viol_count3), 32'd0);
        chk("async_state", 32'(state), 32'd0);
        chk("async_first_ts", 32'(first_ts), 32'd0);
        model_reset();
        @(posedge CLK);
        #1;
        ASYNCRESETN = 1'b1;

        // Failure at stamp 10, then three more violations with arm low
        repeat (7) step(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("ts10_first_ts", 32'(first_ts), 32'(exp_ts(10)));
        chk("ts10_state", 32'(state), 32'd3);
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("sticky_count", 32'(viol_count), 32'd4);
        chk("sticky_fail", 32'(fail), 32'd1);
        chk("sticky_first_ts", 32'(first_ts), 32'(exp_ts(10)));

        // Saturation of the 3-bit counter over nine consecutive violations
        step(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (9) step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("sat_count3", 32'(viol_count3), 32'd7);
        chk("sat_count8", 32'(viol_count), 32'd9);
        chk("sat_pulse", 32'(fail_pulse), 32'd1);

        // Randomized traffic against the model
        begin
            logic a_lvl;
            a_lvl = 1'b1;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(15) == 0) a_lvl = ~a_lvl;
                step(a_lvl, 1'($urandom_range(3) != 0), 1'($urandom_range(2) != 0),
                     1'($urandom_range(59) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
